// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file read front end with busy scoreboard and writeback forwarding
// One-deep operand output stage; stalls issue on RAW/WAW against writes still in flight.
module operand_fetch #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int NREGS  = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_ra,
  input  logic [ADDR_W-1:0] in_rb,
  input  logic [ADDR_W-1:0] in_wb,
  input  logic              in_we,
  input  logic [OP_W-1:0]   in_op,
  output logic [ADDR_W-1:0] rf_ra,
  output logic [ADDR_W-1:0] rf_rb,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] out_wb,
  output logic              out_we,
  output logic [OP_W-1:0]   out_op,
  output logic [NREGS-1:0]  busy,
  output logic              sb_err
);

  logic [NREGS-1:0]  busy_q, busy_d;
  logic [NREGS-1:0]  clr_vec, set_vec;
  logic              sb_err_q, sb_err_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [ADDR_W-1:0] out_wb_q, out_wb_d;
  logic              out_we_q, out_we_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic              haz, accept;

  assign rf_ra = in_ra;
  assign rf_rb = in_rb;

  always_comb begin
    clr_vec = '0;
    if (wb_valid) clr_vec[wb_addr] = 1'b1;
  end

  // A writeback landing this cycle resolves the hazard because its data is forwarded.
  assign haz = (busy_q[in_ra] && !clr_vec[in_ra]) ||
               (busy_q[in_rb] && !clr_vec[in_rb]) ||
               (in_we && busy_q[in_wb] && !clr_vec[in_wb]);

  assign in_ready = !haz && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    set_vec = '0;
    if (accept && in_we) set_vec[in_wb] = 1'b1;
  end

  // Set overrides clear so the newer producer keeps the register reserved.
  assign busy_d   = set_vec | (busy_q & ~clr_vec);
  assign sb_err_d = sb_err_q | (wb_valid && !busy_q[wb_addr]);

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_wb_d    = out_wb_q;
    out_we_d    = out_we_q;
    out_op_d    = out_op_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_a_d     = clr_vec[in_ra] ? wb_data : rf_data1;
      out_b_d     = clr_vec[in_rb] ? wb_data : rf_data2;
      out_wb_d    = in_wb;
      out_we_d    = in_we;
      out_op_d    = in_op;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      sb_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_wb_q    <= '0;
      out_we_q    <= 1'b0;
      out_op_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      sb_err_q    <= sb_err_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_wb_q    <= out_wb_d;
      out_we_q    <= out_we_d;
      out_op_q    <= out_op_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_wb    = out_wb_q;
  assign out_we    = out_we_q;
  assign out_op    = out_op_q;
  assign busy      = busy_q;
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch
// Directed scenarios plus randomized traffic against a behavioural register/scoreboard model.
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, in_we = 1'b0, wb_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] in_ra = '0, in_rb = '0, in_wb = '0, wb_addr = '0;
  logic [3:0] in_op = '0;
  logic [7:0] rf_data1 = '0, rf_data2 = '0, wb_data = '0;
  logic       in_ready, out_valid, out_we, sb_err;
  logic [1:0] rf_ra, rf_rb, out_wb;
  logic [7:0] out_a, out_b;
  logic [3:0] out_op, busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model: register contents, pending writes, output stage.
  logic [7:0] rf_m [4];
  logic [3:0] pend;
  logic       m_valid, m_we, m_err, m_ready, obs_ready;
  logic [7:0] m_a, m_b;
  logic [1:0] m_wb;
  logic [3:0] m_op;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ra(in_ra), .in_rb(in_rb), .in_wb(in_wb), .in_we(in_we), .in_op(in_op),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_wb(out_wb), .out_we(out_we), .out_op(out_op), .busy(busy), .sb_err(sb_err)
  );

  task automatic model_reset();
    pend = '0; m_valid = 0; m_a = '0; m_b = '0; m_wb = '0; m_we = 0; m_op = '0; m_err = 0;
  endtask

  // Present register file data, sample in_ready, then advance one clock and update the model.
  task automatic tick();
    logic h, acc;
    logic [7:0] a, b;
    rf_data1 = rf_m[in_ra];
    rf_data2 = rf_m[in_rb];
    #1;
    obs_ready = in_ready;
    h = (pend[in_ra] && !(wb_valid && wb_addr == in_ra)) ||
        (pend[in_rb] && !(wb_valid && wb_addr == in_rb)) ||
        (in_we && pend[in_wb] && !(wb_valid && wb_addr == in_wb));
    m_ready = !h && (!m_valid || out_ready);
    acc = in_valid && m_ready;
    a = (wb_valid && wb_addr == in_ra) ? wb_data : rf_m[in_ra];
    b = (wb_valid && wb_addr == in_rb) ? wb_data : rf_m[in_rb];
    @(posedge clk);
    if (wb_valid) begin
      if (!pend[wb_addr]) m_err = 1;
      pend[wb_addr] = 0;
      rf_m[wb_addr] = wb_data;
    end
    if (acc) begin
      if (in_we) pend[in_wb] = 1;
      m_valid = 1; m_a = a; m_b = b; m_wb = in_wb; m_we = in_we; m_op = in_op;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic issue(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] wb,
                       input logic we, input logic [3:0] op);
    in_valid = 1; in_ra = ra; in_rb = rb; in_wb = wb; in_we = we; in_op = op;
  endtask

  task automatic test_reset();
    rst = 0;
    rf_m[0] = 8'h11; rf_m[1] = 8'h05; rf_m[2] = 8'hFD; rf_m[3] = 8'h40;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    checks++; if ({out_a, out_b, out_wb, out_we, out_op} !== 23'd0) begin errors++; $display("FAIL rst_payload got %h %h %h %b %h want zeros", out_a, out_b, out_wb, out_we, out_op); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL rst_busy got %b want 0000", busy); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb_err got %b want 0", sb_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic_issue();
    out_ready = 1;
    issue(2'd1, 2'd2, 2'd3, 1'b1, 4'hA);
    checks++; if (rf_ra !== 2'd1 || rf_rb !== 2'd2) begin errors++; $display("FAIL rf_addr got %0d %0d want 1 2", rf_ra, rf_rb); end
    tick();
    in_valid = 0;
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b want 1", obs_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    checks++; if (out_a !== 8'd5 || out_b !== 8'hFD) begin errors++; $display("FAIL basic_operands got %h %h want 05 fd", out_a, out_b); end
    checks++; if (out_wb !== 2'd3 || out_we !== 1'b1 || out_op !== 4'hA) begin errors++; $display("FAIL basic_ctrl got %0d %b %h want 3 1 a", out_wb, out_we, out_op); end
    checks++; if (busy !== 4'b1000) begin errors++; $display("FAIL basic_busy got %b want 1000", busy); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", out_valid); end
  endtask

  task automatic test_forward_stall();
    issue(2'd3, 2'd0, 2'd0, 1'b0, 4'h5);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (obs_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_%0d got ready=%b valid=%b want 0 0", i, obs_ready, out_valid); end
    end
    wb_valid = 1; wb_addr = 2'd3; wb_data = 8'h7F;
    tick();
    wb_valid = 0; in_valid = 0;
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL fwd_in_ready got %b want 1", obs_ready); end
    checks++; if (out_valid !== 1'b1 || out_a !== 8'h7F || out_b !== 8'h11) begin errors++; $display("FAIL fwd_operands got %b %h %h want 1 7f 11", out_valid, out_a, out_b); end
    checks++; if (busy !== 4'b0000 || sb_err !== 1'b0) begin errors++; $display("FAIL fwd_busy got %b err=%b want 0000 0", busy, sb_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    issue(2'd1, 2'd2, 2'd0, 1'b0, 4'h1);
    tick();
    out_ready = 0;
    issue(2'd0, 2'd1, 2'd0, 1'b0, 4'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 8'h05 || out_b !== 8'hFD || out_op !== 4'h1) begin
        errors++; $display("FAIL hold_%0d got ready=%b valid=%b a=%h b=%h op=%h want 0 1 05 fd 1", i, obs_ready, out_valid, out_a, out_b, out_op); end
    end
    out_ready = 1;
    tick();
    checks++; if (obs_ready !== 1'b1 || out_op !== 4'h2 || out_a !== 8'h11 || out_b !== 8'h05) begin
      errors++; $display("FAIL release got ready=%b op=%h a=%h b=%h want 1 2 11 05", obs_ready, out_op, out_a, out_b); end
    issue(2'd2, 2'd2, 2'd1, 1'b0, 4'h3);
    tick();
    in_valid = 0;
    checks++; if (obs_ready !== 1'b1 || out_valid !== 1'b1 || out_op !== 4'h3 || out_a !== 8'hFD || out_b !== 8'hFD) begin
      errors++; $display("FAIL b2b got ready=%b valid=%b op=%h a=%h b=%h want 1 1 3 fd fd", obs_ready, out_valid, out_op, out_a, out_b); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_set_clear_same();
    out_ready = 1;
    issue(2'd0, 2'd0, 2'd2, 1'b1, 4'h4);
    tick();
    checks++; if (busy !== 4'b0100) begin errors++; $display("FAIL sc_pre_busy got %b want 0100", busy); end
    issue(2'd0, 2'd0, 2'd2, 1'b1, 4'h6);
    wb_valid = 1; wb_addr = 2'd2; wb_data = 8'h22;
    tick();
    checks++; if (obs_ready !== 1'b1 || busy !== 4'b0100 || sb_err !== 1'b0) begin
      errors++; $display("FAIL sc_same_cycle got ready=%b busy=%b err=%b want 1 0100 0", obs_ready, busy, sb_err); end
    in_valid = 0; wb_data = 8'h23;
    tick();
    wb_valid = 0;
    checks++; if (busy !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL sc_clear got busy=%b valid=%b want 0000 0", busy, out_valid); end
  endtask

  task automatic test_sb_err();
    wb_valid = 1; wb_addr = 2'd1; wb_data = 8'h33;
    tick();
    wb_valid = 0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (sb_err !== 1'b1 || busy !== 4'b0000) begin errors++; $display("FAIL sb_err_%0d got err=%b busy=%b want 1 0000", i, sb_err, busy); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1;
    issue(2'd0, 2'd3, 2'd1, 1'b1, 4'h7);
    tick();
    issue(2'd0, 2'd3, 2'd2, 1'b1, 4'h8);
    tick();
    in_valid = 0; out_ready = 0;
    checks++; if (out_valid !== 1'b1 || busy !== 4'b0110 || sb_err !== 1'b1) begin
      errors++; $display("FAIL arst_pre got valid=%b busy=%b err=%b want 1 0110 1", out_valid, busy, sb_err); end
    #2 rst = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 4'b0000 || sb_err !== 1'b0) begin
      errors++; $display("FAIL arst_now got valid=%b busy=%b err=%b want 0 0000 0", out_valid, busy, sb_err); end
    checks++; if ({out_a, out_b, out_wb, out_we, out_op} !== 23'd0) begin errors++; $display("FAIL arst_payload got %h %h %h %b %h want zeros", out_a, out_b, out_wb, out_we, out_op); end
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ra     = 2'($urandom_range(0, 3));
      in_rb     = 2'($urandom_range(0, 3));
      in_wb     = 2'($urandom_range(0, 3));
      in_we     = $urandom_range(0, 1);
      in_op     = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      wb_data   = 8'($urandom_range(0, 255));
      wb_valid  = 0;
      if (pend != 4'b0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1;
        wb_addr  = 2'($urandom_range(0, 3));
        while (!pend[wb_addr]) wb_addr = wb_addr + 2'd1;
      end else if ($urandom_range(0, 59) == 0) begin
        wb_valid = 1;
        wb_addr  = 2'($urandom_range(0, 3));
      end
      tick();
      checks++; if (obs_ready !== m_ready) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", n, obs_ready, m_ready); end
      checks++; if (out_valid !== m_valid || busy !== pend || sb_err !== m_err) begin
        errors++; $display("FAIL rnd_state cyc %0d got valid=%b busy=%b err=%b want %b %b %b", n, out_valid, busy, sb_err, m_valid, pend, m_err); end
      checks++; if (out_a !== m_a || out_b !== m_b || out_wb !== m_wb || out_we !== m_we || out_op !== m_op) begin
        errors++; $display("FAIL rnd_payload cyc %0d got %h %h %0d %b %h want %h %h %0d %b %h", n, out_a, out_b, out_wb, out_we, out_op, m_a, m_b, m_wb, m_we, m_op); end
    end
    in_valid = 0; wb_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_forward_stall();
    test_back_to_back();
    test_set_clear_same();
    test_sb_err();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
